// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared AES pipeline constants and block/word types.
//  Revision    : 1.0  initial release
// ============================================================================
package aes_pkg;

    localparam int AES_BLOCK_W         = 128;
    localparam int AES_WORD_W          = 32;
    localparam int AES_WORDS_PER_BLOCK = 4;

    // Round state at which the encryption pipeline raises data_done
    localparam logic [4:0] AES_DONE_STATE = 5'b01010;

    typedef logic [AES_BLOCK_W-1:0] aes_block_t;
    typedef logic [AES_WORD_W-1:0]  aes_word_t;

endpackage
`default_nettype wire

// File: rtl/aes_output_buffer_block_word_select.sv
`default_nettype none
// ============================================================================
//  Module      : block_word_select
//  Description : Picks one 32-bit word out of a 128-bit block, most
//                significant word first (index 0 -> bits 127:96).
//  Revision    : 1.0  initial release
// ============================================================================
module block_word_select
    import aes_pkg::*;
(
    input  aes_block_t   block,
    input  logic [1:0]   index,
    output aes_word_t    word
);

    // Word mux: index 0 is the MSW so the host sees the block in natural order
    always_comb begin
        word = '0;
        case (index)
            2'd0: word = block[127:96];
            2'd1: word = block[95:64];
            2'd2: word = block[63:32];
            2'd3: word = block[31:0];
            default: word = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/aes_output_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : aes_output_buffer
//  Description : Block FIFO between the AES encryption pipeline and the host.
//                Stores whole 128-bit blocks, stalls the pipeline via is_full
//                and serves the host one 32-bit word per read, MSW first.
//  Revision    : 1.0  initial release
// ============================================================================
module aes_output_buffer
    import aes_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  aes_block_t        data_output,
    input  logic              data_done,
    input  logic              clear,
    input  logic              read_word,
    output logic              is_full,
    output aes_word_t         word_out,
    output logic              empty,
    output logic [ADDR_W:0]   block_count
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE    = (ADDR_W+1)'(1);
    localparam logic [1:0]      LAST_WORD  = 2'(AES_WORDS_PER_BLOCK - 1);

    aes_block_t         mem [DEPTH];
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  rd_ptr;
    logic [1:0]         word_idx;
    logic [ADDR_W:0]    count;
    logic [ADDR_W:0]    count_next;

    logic               wr_en;
    logic               rd_en;
    logic               last_pop;
    aes_word_t          head_word;

    // Status is decoded from the registered count only, so neither
    // data_done nor read_word has a combinational path to the outputs.
    assign is_full     = (count == FULL_COUNT);
    assign empty       = (count == '0);
    assign block_count = count;

    // Full blocks writes: the frozen pipeline re-presents the same block,
    // so nothing is lost and nothing is written twice.
    assign wr_en    = data_done && !is_full;
    assign rd_en    = read_word && !empty;
    assign last_pop = rd_en && (word_idx == LAST_WORD);

    // Occupancy changes only on a lone write or a lone final-word pop
    always_comb begin
        count_next = count;
        if (wr_en && !last_pop) begin
            count_next = count + CNT_ONE;
        end else if (!wr_en && last_pop) begin
            count_next = count - CNT_ONE;
        end
    end

    // Block storage; contents need no reset, a flush only moves pointers
    always_ff @(posedge clk) begin
        if (wr_en && !clear) begin
            mem[wr_ptr] <= data_output;
        end
    end

    // Pointers, word index and occupancy; clear outranks write and read
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            word_idx <= '0;
            count    <= '0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            word_idx <= '0;
            count    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                word_idx <= word_idx + 1'b1;
                if (last_pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
            count <= count_next;
        end
    end

    block_word_select u_word_select (
        .block (mem[rd_ptr]),
        .index (word_idx),
        .word  (head_word)
    );

    // Head entry is meaningless when empty, so present zero instead
    assign word_out = empty ? '0 : head_word;

endmodule
`default_nettype wire

// File: tb/tb_aes_output_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_output_buffer
//  Description : Self-checking bench for aes_output_buffer with a queue-based
//                reference model and directed stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_aes_output_buffer;
    import aes_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic           clk = 1'b0;
    logic           n_rst = 1'b0;
    logic           data_done = 1'b0;
    logic           clear = 1'b0;
    logic           read_word = 1'b0;
    aes_block_t     data_output = '0;
    logic           is_full;
    logic           empty;
    aes_word_t      word_out;
    logic [AW:0]    block_count;

    int vectors     = 0;
    int miscompares = 0;
    bit run         = 1'b0;

    always #5 clk = ~clk;

    aes_output_buffer #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .data_output (data_output),
        .data_done   (data_done),
        .clear       (clear),
        .read_word   (read_word),
        .is_full     (is_full),
        .word_out    (word_out),
        .empty       (empty),
        .block_count (block_count)
    );

    // ------------------------------------------------------------------
    // Reference model: queue of whole blocks plus the word offset in head
    // ------------------------------------------------------------------
    aes_block_t mq[$];
    int         widx = 0;

    function automatic aes_word_t m_word();
        if (mq.size() == 0) return '0;
        return aes_word_t'(mq[0] >> (96 - 32*widx));
    endfunction

    always @(negedge n_rst) begin
        mq.delete();
        widx = 0;
    end

    always @(posedge clk) begin
        bit mfull;
        bit memp;
        if (n_rst) begin
            mfull = (mq.size() == DEPTH);
            memp  = (mq.size() == 0);
            if (clear) begin
                mq.delete();
                widx = 0;
            end else begin
                if (read_word && !memp) begin
                    if (widx == 3) begin
                        void'(mq.pop_front());
                        widx = 0;
                    end else begin
                        widx++;
                    end
                end
                if (data_done && !mfull) mq.push_back(data_output);
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (n_rst && run) begin
            chk("model_word_out", word_out, m_word());
            chk("model_empty", empty, (mq.size() == 0));
            chk("model_is_full", is_full, (mq.size() == DEPTH));
            chk("model_block_count", block_count, mq.size());
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic cyc(input logic d, input aes_block_t v, input logic r, input logic c);
        data_done   = d;
        data_output = v;
        read_word   = r;
        clear       = c;
        @(negedge clk);
    endtask

    task automatic read_block(input aes_block_t b, input string tag);
        for (int i = 0; i < 4; i++) begin
            chk(tag, word_out, (b >> (96 - 32*i)) & 128'hFFFF_FFFF);
            cyc(1'b0, '0, 1'b1, 1'b0);
        end
    endtask

    function automatic aes_block_t mk(input logic [31:0] base);
        return {base, base + 32'd1, base + 32'd2, base + 32'd3};
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        aes_block_t blk;
        aes_block_t a [5];
        aes_word_t  t1w [4];
        aes_word_t  got [$];
        int         reads;
        int         guard;
        int         k;
        logic       fb;
        logic       d;

        // Reset state
        #1;
        chk("reset_empty", empty, 1'b1);
        chk("reset_is_full", is_full, 1'b0);
        chk("reset_block_count", block_count, 0);
        chk("reset_word_out", word_out, 0);
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        run   = 1'b1;
        @(negedge clk);

        // 1: single block, four MSW-first words
        blk = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        t1w[0] = 32'h00112233; t1w[1] = 32'h44556677;
        t1w[2] = 32'h8899AABB; t1w[3] = 32'hCCDDEEFF;
        cyc(1'b1, blk, 1'b0, 1'b0);
        chk("t1_block_count", block_count, 1);
        chk("t1_empty", empty, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("t1_word", word_out, t1w[i]);
            cyc(1'b0, '0, 1'b1, 1'b0);
        end
        chk("t1_empty_after", empty, 1'b1);
        chk("t1_word_zero", word_out, 0);

        // 2: fill to full, hold A5 until space frees
        for (int i = 0; i < 5; i++) a[i] = mk(32'hA000_0000 + 32'(i) * 32'h10);
        for (int i = 0; i < 4; i++) cyc(1'b1, a[i], 1'b0, 1'b0);
        chk("t2_is_full", is_full, 1'b1);
        chk("t2_count_full", block_count, 4);
        reads = 0;
        guard = 0;
        do begin
            fb = is_full;
            cyc(1'b1, a[4], (reads < 4), 1'b0);
            if (reads < 4) reads++;
            guard++;
        end while (fb && guard < 20);
        chk("t2_hold_bound", (guard < 20), 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("t2_count_after_refill", block_count, 4);
        for (int i = 1; i < 5; i++) read_block(a[i], "t2_order");
        chk("t2_drained", empty, 1'b1);

        // 3: write coinciding with final-word pop at count 2
        a[0] = mk(32'hB000_0000);
        a[1] = mk(32'hB000_0010);
        a[2] = mk(32'hB000_0020);
        cyc(1'b1, a[0], 1'b0, 1'b0);
        cyc(1'b1, a[1], 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b1, a[2], 1'b1, 1'b0);
        chk("t3_count_steady", block_count, 2);
        chk("t3_head", word_out, 32'hB000_0010);
        read_block(a[1], "t3_b2");
        read_block(a[2], "t3_b3");

        // 4: ten blocks streamed with continuous reads
        k = 0;
        for (int c = 0; c < 80 && got.size() < 40; c++) begin
            d = (c % 4 == 0) && (k < 10);
            if (!empty) got.push_back(word_out);
            cyc(d, mk(32'h5000_0000 + 32'(k) * 32'd4), 1'b1, 1'b0);
            if (d) k++;
        end
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("t4_word_total", got.size(), 40);
        for (int w = 0; w < got.size(); w++) chk("t4_stream", got[w], 32'h5000_0000 + 32'(w));

        // 5: reads while empty are ignored
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        chk("t5_empty", empty, 1'b1);
        chk("t5_count", block_count, 0);
        a[0] = mk(32'hC000_0000);
        cyc(1'b1, a[0], 1'b0, 1'b0);
        chk("t5_word0", word_out, 32'hC000_0000);
        read_block(a[0], "t5_block");

        // 6: clear mid-block with a concurrent write
        for (int i = 0; i < 3; i++) cyc(1'b1, mk(32'hD000_0000 + 32'(i) * 32'h10), 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b1, mk(32'hD000_0030), 1'b1, 1'b1);
        chk("t6_clear_count", block_count, 0);
        chk("t6_clear_empty", empty, 1'b1);
        chk("t6_clear_full", is_full, 1'b0);
        chk("t6_clear_word", word_out, 0);
        a[0] = mk(32'hD000_0040);
        cyc(1'b1, a[0], 1'b0, 1'b0);
        chk("t6_next_word0", word_out, 32'hD000_0040);
        read_block(a[0], "t6_next");

        // 6b: asynchronous reset mid-read
        cyc(1'b1, mk(32'hE000_0000), 1'b0, 1'b0);
        cyc(1'b1, mk(32'hE000_0010), 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        read_word = 1'b0;
        #2;
        n_rst = 1'b0;
        #1;
        chk("t6_rst_empty", empty, 1'b1);
        chk("t6_rst_count", block_count, 0);
        chk("t6_rst_word", word_out, 0);
        chk("t6_rst_full", is_full, 1'b0);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        a[0] = mk(32'hF000_0000);
        cyc(1'b1, a[0], 1'b0, 1'b0);
        chk("t6_post_rst_count", block_count, 1);
        read_block(a[0], "t6_post_rst");
        chk("t6_final_empty", empty, 1'b1);

        run = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
